ps2_rx_ctrl: RTL and testbench

PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

---
 rtl/ps2_rx_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_ps2_rx_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver.
// Synchronises the raw PS/2 clock and data lines into the clk domain and
// detects falling edges of the PS/2 clock. Each 11-bit frame (start, eight
// data bits LSB first, odd parity, stop) is checked and delivered as one byte.
// Parity, framing, overrun and inactivity timeout problems are each reported
// as a single-cycle rx_err pulse, and err_code holds the cause until the
// next error.
//
// Handshake: rx_valid rises when a good frame is accepted and stays high,
// with rx_data stable, until the first clk edge that sees rx_ack=1. rx_ack
// is ignored while rx_valid=0. If a frame completes on the same edge that
// rx_ack retires the previous byte, the new byte is taken and rx_valid stays
// high. If a frame completes while a byte is still pending, the frame is
// dropped and an overrun is reported.
module ps2_rx_ctrl #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_en,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [1:0] err_code,
    output logic [2:0] bit_cnt,
    output logic       busy,
    output logic [1:0] fsm_state
);

    // Width of the inactivity counter. It only has to reach TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAMING = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Synchroniser flops. They reset to 1 so that releasing reset with the
    // bus idle (both lines high) cannot produce a false falling edge.
    logic clk_s1;
    logic clk_s2;
    logic clk_s3;
    logic data_s1;
    logic data_s2;

    logic fall;
    logic data_bit;

    // Frame datapath.
    logic [7:0]    shreg;
    logic          parity_ok;
    logic [TW-1:0] tcnt;

    // Per-cycle actions decoded from state, edge and enable.
    logic take_start;
    logic take_data;
    logic take_parity;
    logic take_stop;
    logic timeout_hit;

    // Frame outcome, meaningful only when take_stop is high.
    logic       stop_err;
    logic [1:0] stop_code;
    logic       stop_accept;

    // ------------------------------------------------------------------
    // Input synchronisers and falling-edge detection
    // ------------------------------------------------------------------

    // Two-flop synchronisers for both lines, plus a third clock flop used
    // for edge detection.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // A pin fall reaches clk_s2 two edges later. The FSM therefore acts on
    // it at the third edge, and samples data from its own second stage.
    always_comb begin
        fall     = !clk_s2 && clk_s3;
        data_bit = data_s2;
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. Priority is disable, then a falling edge, then timeout,
    // so a fall that coincides with the timeout point keeps the frame alive.
    always_comb begin
        state_nxt = state;
        if (!rx_en) begin
            state_nxt = ST_IDLE;
        end else if (fall) begin
            case (state)
                ST_IDLE:   state_nxt = data_bit ? ST_IDLE : ST_DATA;
                ST_DATA:   state_nxt = (bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP:   state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && tcnt == T_LAST) begin
            state_nxt = ST_IDLE;
        end
    end

    // FSM outputs: status, debug view of the state, and per-cycle actions.
    always_comb begin
        busy        = (state != ST_IDLE);
        fsm_state   = state;
        take_start  = rx_en && fall && (state == ST_IDLE) && !data_bit;
        take_data   = rx_en && fall && (state == ST_DATA);
        take_parity = rx_en && fall && (state == ST_PARITY);
        take_stop   = rx_en && fall && (state == ST_STOP);
        timeout_hit = rx_en && !fall && (state != ST_IDLE) && (tcnt == T_LAST);
    end

    // Outcome of the stop bit, in priority order: framing, parity, overrun,
    // accept. A byte retired by rx_ack on this same edge is not an overrun.
    always_comb begin
        stop_err    = 1'b0;
        stop_code   = ERR_OVERRUN;
        stop_accept = 1'b0;
        if (!data_bit) begin
            stop_err  = 1'b1;
            stop_code = ERR_FRAMING;
        end else if (!parity_ok) begin
            stop_err  = 1'b1;
            stop_code = ERR_PARITY;
        end else if (rx_valid && !rx_ack) begin
            stop_err  = 1'b1;
            stop_code = ERR_OVERRUN;
        end else begin
            stop_accept = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Data-bit counter. It counts only in DATA, and wrapping 7 -> 0 on the
    // eighth bit leaves it at 0 for PARITY and STOP. Aborts clear it.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            bit_cnt <= 3'd0;
        end else if (!rx_en || timeout_hit || take_start) begin
            bit_cnt <= 3'd0;
        end else if (take_data) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Shift register. Bits arrive LSB first, so they enter at the top.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            shreg <= 8'h00;
        end else if (take_start) begin
            shreg <= 8'h00;
        end else if (take_data) begin
            shreg <= {data_bit, shreg[7:1]};
        end
    end

    // Odd parity over the eight data bits and the received parity bit.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            parity_ok <= 1'b0;
        end else if (take_parity) begin
            parity_ok <= ^{shreg, data_bit};
        end
    end

    // Inactivity counter. It restarts on every fall, is held at 0 in IDLE,
    // and counts otherwise.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            tcnt <= '0;
        end else if (fall || state_nxt == ST_IDLE) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Received byte and its valid flag. These survive rx_en=0.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (take_stop && stop_accept) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

    // Error pulse and sticky cause code.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rx_err   <= 1'b0;
            err_code <= ERR_OVERRUN;
        end else if (take_stop && stop_err) begin
            rx_err   <= 1'b1;
            err_code <= stop_code;
        end else if (timeout_hit) begin
            rx_err   <= 1'b1;
            err_code <= ERR_TIMEOUT;
        end else begin
            rx_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl. A frame-level model tracks the bits received on
// the PS/2 pins and derives every output each cycle. Directed frames cover
// the good, parity, framing, overrun, timeout, disable and reset cases.
module tb_ps2_rx_ctrl;

  localparam int TO = 200;
  localparam int HALF = 50;
  localparam int LAT = 3;

  logic       clk;
  logic       clear_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rx_en;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [1:0] err_code;
  logic [2:0] bit_cnt;
  logic       busy;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  ps2_rx_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_en     (rx_en),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .err_code  (err_code),
    .bit_cnt   (bit_cnt),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame bits: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
  function automatic logic [10:0] frame(input logic [7:0] b, input logic p, input logic s);
    return {s, p, b, 1'b0};
  endfunction

  // ---------------- model ----------------
  // Pin falls and data are seen at the negedge after they happen, and the
  // DUT acts on them LAT clk edges later. rx_ack/rx_en act one edge later.
  logic [LAT-1:0] pf;
  logic [LAT-1:0] pd;
  logic           pin_prev;
  logic           ack_prev;
  logic           en_prev;
  logic [10:0]    m_bits;
  int             m_count;   // 0 = idle, otherwise number of frame bits taken
  int             m_since;
  logic           m_valid;
  logic [7:0]     m_data;
  logic           m_err;
  logic [1:0]     m_code;

  initial begin
    pf = '0; pd = '0; pin_prev = 1'b1; ack_prev = 1'b0; en_prev = 1'b1;
    m_bits = '0; m_count = 0; m_since = 0;
    m_valid = 1'b0; m_data = 8'h00; m_err = 1'b0; m_code = 2'b00;
  end

  always @(negedge clk) begin : model_cmp
    logic det, fall_a, data_a, ack_a, en_a, accept;
    int   exp_bc;
    det    = pin_prev && !ps2_clk;
    fall_a = pf[LAT-1];
    data_a = pd[LAT-1];
    pf = {pf[LAT-2:0], det};
    pd = {pd[LAT-2:0], ps2_data};
    pin_prev = ps2_clk;
    ack_a = ack_prev;
    en_a  = en_prev;
    ack_prev = rx_ack;
    en_prev  = rx_en;
    accept = 1'b0;
    if (!clear_n) begin
      pf = '0; pd = '0;
      m_bits = '0; m_count = 0; m_since = 0;
      m_valid = 1'b0; m_data = 8'h00; m_err = 1'b0; m_code = 2'b00;
    end else begin
      m_err = 1'b0;
      if (!en_a) begin
        m_count = 0;
        m_since = 0;
      end else if (fall_a) begin
        m_since = 0;
        if (m_count == 0) begin
          if (!data_a) begin
            m_bits = '0;
            m_count = 1;
          end
        end else begin
          m_bits[m_count] = data_a;
          m_count++;
          if (m_count == 11) begin
            m_count = 0;
            if (!m_bits[10]) begin
              m_err = 1'b1; m_code = 2'b10;
            end else if ($countones(m_bits[9:1]) % 2 == 0) begin
              m_err = 1'b1; m_code = 2'b01;
            end else if (m_valid && !ack_a) begin
              m_err = 1'b1; m_code = 2'b00;
            end else begin
              accept = 1'b1;
            end
          end
        end
      end else if (m_count != 0) begin
        m_since++;
        if (m_since == TO) begin
          m_err = 1'b1; m_code = 2'b11;
          m_count = 0; m_since = 0;
        end
      end
      if (accept) begin
        m_valid = 1'b1;
        m_data  = m_bits[8:1];
      end else if (ack_a) begin
        m_valid = 1'b0;
      end
    end
    exp_bc = (m_count >= 1 && m_count <= 8) ? m_count - 1 : 0;
    check("cyc_rx_data", 32'(rx_data), 32'(m_data));
    check("cyc_rx_valid", 32'(rx_valid), 32'(m_valid));
    check("cyc_rx_err", 32'(rx_err), 32'(m_err));
    check("cyc_err_code", 32'(err_code), 32'(m_code));
    check("cyc_busy", 32'(busy), 32'(m_count != 0));
    check("cyc_bit_cnt", 32'(bit_cnt), 32'(exp_bc));
    if (rx_err) err_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send the first n bits of f. With ack_on_stop, rx_ack is pulsed so that
  // the DUT sees it on the same edge the stop bit is acted upon.
  task automatic send_bits(input logic [10:0] f, input int n, input bit ack_on_stop);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF / 2) tick();
      ps2_clk = 1'b0;
      if (ack_on_stop && i == 10) begin
        repeat (LAT - 1) tick();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        repeat (HALF - LAT) tick();
      end else begin
        repeat (HALF) tick();
      end
      ps2_clk = 1'b1;
      repeat (HALF / 2) tick();
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    tick();
  endtask

  // ---------------- stimulus with hand-computed expectations ----------------
  initial begin : main
    int e0;
    clear_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rx_en = 1'b1; rx_ack = 1'b0;
    repeat (3) tick();
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_err", 32'(rx_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    clear_n = 1'b1;
    repeat (10) tick();

    // Good frame 0xA5 (four ones, parity 1).
    e0 = err_seen;
    send_bits(frame(8'hA5, 1'b1, 1'b1), 11, 1'b0);
    repeat (5) tick();
    check("a5_valid", 32'(rx_valid), 32'd1);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_no_err", 32'(err_seen - e0), 32'd0);
    ack_pulse();
    check("a5_ack_clears", 32'(rx_valid), 32'd0);

    // 0x3C has four ones, so parity 0 is wrong.
    e0 = err_seen;
    send_bits(frame(8'h3C, 1'b0, 1'b1), 11, 1'b0);
    repeat (5) tick();
    check("par_err_pulses", 32'(err_seen - e0), 32'd1);
    check("par_err_code", 32'(err_code), 32'd1);
    check("par_valid_low", 32'(rx_valid), 32'd0);

    // Stop bit 0 is a framing error even with correct parity.
    e0 = err_seen;
    send_bits(frame(8'h01, 1'b0, 1'b0), 11, 1'b0);
    repeat (5) tick();
    check("frm_err_pulses", 32'(err_seen - e0), 32'd1);
    check("frm_err_code", 32'(err_code), 32'd2);
    send_bits(frame(8'h02, 1'b0, 1'b1), 11, 1'b0);
    repeat (5) tick();
    check("frm_next_data", 32'(rx_data), 32'h02);
    check("frm_next_valid", 32'(rx_valid), 32'd1);
    ack_pulse();

    // Overrun: 0x55 is left unacknowledged when 0xAA arrives.
    send_bits(frame(8'h55, 1'b1, 1'b1), 11, 1'b0);
    e0 = err_seen;
    send_bits(frame(8'hAA, 1'b1, 1'b1), 11, 1'b0);
    repeat (5) tick();
    check("ovr_err_pulses", 32'(err_seen - e0), 32'd1);
    check("ovr_err_code", 32'(err_code), 32'd0);
    check("ovr_data_kept", 32'(rx_data), 32'h55);
    check("ovr_valid", 32'(rx_valid), 32'd1);

    // Completion on the same edge as the ack: accepted, no overrun.
    e0 = err_seen;
    send_bits(frame(8'h3C, 1'b1, 1'b1), 11, 1'b1);
    repeat (5) tick();
    check("coin_no_err", 32'(err_seen - e0), 32'd0);
    check("coin_data", 32'(rx_data), 32'h3C);
    check("coin_valid", 32'(rx_valid), 32'd1);

    // rx_en dropped mid-frame: silent abort, pending byte retained.
    e0 = err_seen;
    send_bits(frame(8'hFF, 1'b1, 1'b1), 5, 1'b0);
    check("en_busy_before", 32'(busy), 32'd1);
    rx_en = 1'b0;
    repeat (2) tick();
    check("en_busy_after", 32'(busy), 32'd0);
    check("en_bit_cnt", 32'(bit_cnt), 32'd0);
    check("en_no_err", 32'(err_seen - e0), 32'd0);
    check("en_data_kept", 32'(rx_data), 32'h3C);
    check("en_valid_kept", 32'(rx_valid), 32'd1);
    rx_en = 1'b1;
    repeat (5) tick();
    ack_pulse();

    // Timeout: start plus three data bits, then the line goes quiet.
    e0 = err_seen;
    send_bits(frame(8'h07, 1'b0, 1'b1), 4, 1'b0);
    check("tmo_busy_mid", 32'(busy), 32'd1);
    check("tmo_bit_cnt_mid", 32'(bit_cnt), 32'd3);
    repeat (TO + 50) tick();
    check("tmo_err_pulses", 32'(err_seen - e0), 32'd1);
    check("tmo_err_code", 32'(err_code), 32'd3);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_bit_cnt", 32'(bit_cnt), 32'd0);

    // Reset after five data bits, then a fresh frame.
    send_bits(frame(8'hFF, 1'b1, 1'b1), 6, 1'b0);
    clear_n = 1'b0;
    #2;
    check("mrst_rx_data", 32'(rx_data), 32'h00);
    check("mrst_rx_valid", 32'(rx_valid), 32'd0);
    check("mrst_err_code", 32'(err_code), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_bit_cnt", 32'(bit_cnt), 32'd0);
    tick();
    clear_n = 1'b1;
    repeat (10) tick();
    check("mrst_idle_after", 32'(busy), 32'd0);
    send_bits(frame(8'h81, 1'b1, 1'b1), 11, 1'b0);
    repeat (5) tick();
    check("mrst_next_data", 32'(rx_data), 32'h81);
    check("mrst_next_valid", 32'(rx_valid), 32'd1);
    ack_pulse();
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
